tile_redraw_engine: RTL
=======================

TILE_REDRAW_ENGINE -- requirements
Module: tile_redraw_engine

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- TILE_W, 20, tile width in pixels
- TILE_H, 20, tile height in pixels
- SCREEN_W, 160, framebuffer width
- SCREEN_H, 120, framebuffer height
- GRID_W, 4, grid coordinate width
- COLOUR_W, 9, colour width
- ADDR_W, 15, map memory address width
- RD_LAT, 2, map memory read latency in cycles, 1..4
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock
- resetn, in, 1, reset, asynchronous, active-low
- start, in, 1, request a redraw of one tile
- grid_x, in, GRID_W, tile column
- grid_y, in, GRID_W, tile row
- mode, in, 1, 0 = copy from map memory, 1 = solid fill
- fill_colour, in, COLOUR_W, colour used in fill mode
- map_address, out, ADDR_W, read address to map memory
- map_q, in, COLOUR_W, map memory read data
- x, out, 8, VGA pixel x
- y, out, 7, VGA pixel y
- colour, out, COLOUR_W, VGA pixel colour
- plot, out, 1, VGA write enable
- busy, out, 1, high while a redraw is in progress
- done, out, 1, one-cycle completion pulse

Function
REQ-003 The block SHALL use states IDLE, RUN, DRAIN and DONE.
REQ-004 In IDLE with start=1, the block SHALL latch grid_x, grid_y, mode and fill_colour, clear pixel counters px=py=0, and enter RUN. Cycle 0 is the first cycle after that edge.
REQ-005 Start SHALL be ignored in every state except IDLE. Latched values SHALL NOT change mid-operation.
REQ-006 In RUN, pixel k=py*TILE_W+px SHALL be issued in cycle k. px increments each cycle; at px=TILE_W-1 it wraps to 0 and py increments.
REQ-007 Pixel coordinates: X=grid_x*TILE_W+px and Y=grid_y*TILE_H+py, computed at width >= 12 bits with no truncation before the compare in REQ-010.
REQ-008 map_address SHALL equal Y*SCREEN_W+X truncated to ADDR_W and be registered-free (valid in cycle k). It SHALL hold its last value outside RUN.
REQ-009 After issuing the last pixel (k=N-1, N=TILE_W*TILE_H), the block SHALL enter DRAIN for exactly RD_LAT cycles, then DONE for one cycle, then IDLE.
REQ-010 For pixel k, in cycle k+RD_LAT:
- x=X[7:0] and y=Y[6:0], carried through an RD_LAT-deep shift register;
- plot=1 only if X<SCREEN_W and Y<SCREEN_H, otherwise plot=0 (clipped, still counted).
REQ-011 colour SHALL be map_q in copy mode and the latched fill_colour in fill mode. In fill mode the read address is still driven but map_q is unused.
REQ-012 plot SHALL be 0 in every cycle with no pixel in the pipeline.
REQ-013 busy SHALL be 1 from cycle 0 through cycle N+RD_LAT-1, and 0 otherwise.
REQ-014 done SHALL be 1 only in cycle N+RD_LAT (the DONE state).
REQ-015 If start=1 during DONE, it SHALL be ignored. A new start is accepted in IDLE on the following cycle at the earliest.
REQ-016 Exactly N pixels SHALL be issued per accepted start. Exactly one done pulse SHALL follow, including when all pixels are clipped.

Reset
REQ-017 resetn=0 SHALL immediately (asynchronously) force:
- state to IDLE;
- px, py and the pipeline to 0;
- plot, busy, done, x, y, colour and map_address to 0.
REQ-018 Reset mid-RUN or mid-DRAIN SHALL abort the redraw with no done pulse. No plot SHALL be asserted after reset until a new start.

Verification
REQ-019 Copy mode, grid (0,0), defaults, memory model with latency 2 returning q=address[8:0]:
- first map_address 0 in cycle 0;
- first plot in cycle 2 with x=0, y=0, colour=0;
- 400 plots total, last at x=19, y=19;
- done in cycle 402 only.
REQ-020 Fill mode, grid (7,5), fill_colour=9'h1C0:
- plots cover x 140..159, y 100..119;
- first map_address 16140;
- every colour=9'h1C0;
- 400 plots.
REQ-021 Clipping, grid (8,0): zero plots, busy for 402 cycles, a single done in cycle 402.
REQ-022 Start pulsed during RUN with different grid and mode: no effect on the current tile; exactly one done; block returns to IDLE.
REQ-023 resetn low for 1 cycle at cycle 150 of a redraw: plot, busy and done go to 0 immediately; no done follows; a fresh start then completes normally in 402 cycles.
REQ-024 Sweep RD_LAT=1 and RD_LAT=4: the first plot lands in cycle RD_LAT and done lands in cycle 400+RD_LAT.

Source files
------------

// File: rtl/tile_redraw_engine.sv
// Redraws one tile of a VGA framebuffer. Each pixel is copied from map memory or filled with a solid colour.
// The pixel coordinates ride a shift register as deep as the memory latency, so they meet map_q at the output.
module tile_redraw_engine #(
  parameter int TILE_W   = 20,
  parameter int TILE_H   = 20,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int GRID_W   = 4,
  parameter int COLOUR_W = 9,
  parameter int ADDR_W   = 15,
  parameter int RD_LAT   = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [GRID_W-1:0]   grid_x,
  input  logic [GRID_W-1:0]   grid_y,
  input  logic                mode,
  input  logic [COLOUR_W-1:0] fill_colour,
  output logic [ADDR_W-1:0]   map_address,
  input  logic [COLOUR_W-1:0] map_q,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int PXW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int PYW = (TILE_H > 1) ? $clog2(TILE_H) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [PXW-1:0]        px_q, px_d;
  logic [PYW-1:0]        py_q, py_d;
  logic [2:0]            drain_q, drain_d;
  logic [GRID_W-1:0]     gx_q, gx_d, gy_q, gy_d;
  logic                  mode_q, mode_d;
  logic [COLOUR_W-1:0]   fill_q, fill_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;

  logic [RD_LAT-1:0]       pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0]       pipe_plot_q, pipe_plot_d;
  logic [RD_LAT-1:0][7:0]  pipe_x_q, pipe_x_d;
  logic [RD_LAT-1:0][6:0]  pipe_y_q, pipe_y_d;

  logic                  issue;
  logic                  row_end;
  logic                  last_pix;
  logic                  drain_last;
  logic [15:0]           x_full;
  logic [15:0]           y_full;
  logic                  in_bounds;
  logic [ADDR_W-1:0]     addr_now;

  // Full-width coordinates so that off-screen tiles clip instead of wrapping.
  assign x_full     = 16'(gx_q) * 16'(TILE_W) + 16'(px_q);
  assign y_full     = 16'(gy_q) * 16'(TILE_H) + 16'(py_q);
  assign in_bounds  = (x_full < 16'(SCREEN_W)) && (y_full < 16'(SCREEN_H));
  assign addr_now   = ADDR_W'(32'(y_full) * 32'(SCREEN_W) + 32'(x_full));
  assign row_end    = (px_q == PXW'(TILE_W - 1));
  assign last_pix   = row_end && (py_q == PYW'(TILE_H - 1));
  assign drain_last = (drain_q == 3'(RD_LAT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_pix) state_d = DRAIN;
      DRAIN:   if (drain_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issue = (state_q == RUN);
    busy  = (state_q == RUN) || (state_q == DRAIN);
    done  = (state_q == DONE);
  end

  always_comb begin
    px_d    = px_q;
    py_d    = py_q;
    drain_d = drain_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    addr_d  = addr_q;
    if (state_q == IDLE && start) begin
      gx_d   = grid_x;
      gy_d   = grid_y;
      mode_d = mode;
      fill_d = fill_colour;
      px_d   = '0;
      py_d   = '0;
    end
    if (issue) begin
      addr_d  = addr_now;
      drain_d = '0;
      if (row_end) begin
        px_d = '0;
        py_d = last_pix ? '0 : py_q + PYW'(1);
      end else begin
        px_d = px_q + PXW'(1);
      end
    end
    if (state_q == DRAIN) begin
      drain_d = drain_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      px_q    <= '0;
      py_q    <= '0;
      drain_q <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      mode_q  <= 1'b0;
      fill_q  <= '0;
      addr_q  <= '0;
    end else begin
      px_q    <= px_d;
      py_q    <= py_d;
      drain_q <= drain_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      addr_q  <= addr_d;
    end
  end

  // The address is combinational while issuing, and the last value is held otherwise.
  assign map_address = issue ? addr_now : addr_q;

  always_comb begin
    pipe_vld_d     = '0;
    pipe_plot_d    = '0;
    pipe_x_d       = '0;
    pipe_y_d       = '0;
    pipe_vld_d[0]  = issue;
    pipe_plot_d[0] = issue && in_bounds;
    pipe_x_d[0]    = issue ? x_full[7:0] : 8'd0;
    pipe_y_d[0]    = issue ? y_full[6:0] : 7'd0;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_plot_d[i] = pipe_plot_q[i-1];
      pipe_x_d[i]    = pipe_x_q[i-1];
      pipe_y_d[i]    = pipe_y_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pipe_vld_q  <= '0;
      pipe_plot_q <= '0;
      pipe_x_q    <= '0;
      pipe_y_q    <= '0;
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      pipe_plot_q <= pipe_plot_d;
      pipe_x_q    <= pipe_x_d;
      pipe_y_q    <= pipe_y_d;
    end
  end

  assign plot   = pipe_plot_q[RD_LAT-1];
  assign x      = pipe_x_q[RD_LAT-1];
  assign y      = pipe_y_q[RD_LAT-1];
  assign colour = pipe_vld_q[RD_LAT-1] ? (mode_q ? fill_q : map_q) : '0;

endmodule
